// File: rtl/param_seg_counter.sv
// Modulo-MOD up/down counter built from cascaded SEG_W-bit segments, with a
// registered wrap pulse and a saturating wrap counter.
module param_seg_counter #(
    parameter int MOD    = 40000,
    parameter int SEG_W  = 16,
    parameter int WRAP_W = 8,
    localparam int W     = $clog2(MOD),
    localparam int NSEG  = (W + SEG_W - 1) / SEG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic              clr,
    input  logic              load,
    input  logic [W-1:0]      load_val,
    output logic [W-1:0]      q,
    output logic              tc,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

    logic [W-1:0]      load_sat;
    logic [W-1:0]      wrap_val;
    logic [NSEG-1:0]   carry;
    logic              wrap_next;
    logic              wrap_reg;
    logic [WRAP_W-1:0] wrap_cnt_next;
    logic [WRAP_W-1:0] wrap_cnt_reg;

    // Terminal detection uses the whole W-bit value so non-power-of-two moduli wrap exactly.
    assign tc       = dir ? (q == MAX_VAL) : (q == '0);
    assign load_sat = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    assign wrap_val = dir ? '0 : MAX_VAL;
    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NSEG; gi++) begin : g_seg
            localparam int LO = gi * SEG_W;
            // The top segment is narrowed so q never carries padding bits.
            localparam int SW = (gi == NSEG - 1) ? (W - LO) : SEG_W;

            logic [SW-1:0] seg_reg;
            logic [SW-1:0] seg_next;

            if (gi < NSEG - 1) begin : g_carry
                logic seg_term;
                assign seg_term     = dir ? (&seg_reg) : (seg_reg == '0);
                assign carry[gi+1]  = carry[gi] & seg_term;
            end

            always_comb begin
                seg_next = seg_reg;
                if (clr) begin
                    seg_next = '0;
                end else if (load) begin
                    seg_next = load_sat[LO +: SW];
                end else if (en) begin
                    if (tc) begin
                        seg_next = wrap_val[LO +: SW];
                    end else if (carry[gi]) begin
                        seg_next = dir ? (seg_reg + SW'(1)) : (seg_reg - SW'(1));
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    seg_reg <= '0;
                end else begin
                    seg_reg <= seg_next;
                end
            end

            assign q[LO +: SW] = seg_reg;
        end
    endgenerate

    // clr and load outrank a coincident wrap, so they also suppress the pulse.
    assign wrap_next = ~clr & ~load & en & tc;

    always_comb begin
        wrap_cnt_next = wrap_cnt_reg;
        if (clr) begin
            wrap_cnt_next = '0;
        end else if (wrap_next && (wrap_cnt_reg != '1)) begin
            wrap_cnt_next = wrap_cnt_reg + WRAP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_reg     <= 1'b0;
            wrap_cnt_reg <= '0;
        end else begin
            wrap_reg     <= wrap_next;
            wrap_cnt_reg <= wrap_cnt_next;
        end
    end

    assign wrap     = wrap_reg;
    assign wrap_cnt = wrap_cnt_reg;

endmodule

// File: tb/tb_param_seg_counter.sv
// Scoreboard bench for param_seg_counter (MOD=10, SEG_W=2, WRAP_W=2) against
// an arithmetic reference model.
module tb_param_seg_counter;

    localparam int MOD    = 10;
    localparam int SEG_W  = 2;
    localparam int WRAP_W = 2;
    localparam int W      = $clog2(MOD);
    localparam int SAT    = (1 << WRAP_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              dir = 1'b0;
    logic              clr = 1'b0;
    logic              load = 1'b0;
    logic [W-1:0]      load_val = '0;
    logic [W-1:0]      q;
    logic              tc;
    logic              wrap;
    logic [WRAP_W-1:0] wrap_cnt;

    param_seg_counter #(.MOD(MOD), .SEG_W(SEG_W), .WRAP_W(WRAP_W)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
        .load_val(load_val), .q(q), .tc(tc), .wrap(wrap), .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int wrap;
        int cnt;
        int tc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_q = 0, m_w = 0, m_c = 0;
    int   n_item = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // Reference behaviour: one clock edge with the currently driven inputs.
    task automatic model_step();
        if (clr) begin
            m_q = 0; m_w = 0; m_c = 0;
        end else if (load) begin
            m_q = (int'(load_val) < MOD) ? int'(load_val) : MOD - 1;
            m_w = 0;
        end else if (en) begin
            m_w = 0;
            if (dir) begin
                if (m_q == MOD - 1) begin m_q = 0; m_w = 1; end
                else m_q = m_q + 1;
            end else begin
                if (m_q == 0) begin m_q = MOD - 1; m_w = 1; end
                else m_q = m_q - 1;
            end
            if (m_w == 1 && m_c < SAT) m_c = m_c + 1;
        end else begin
            m_w = 0;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.q    = m_q;
        e.wrap = m_w;
        e.cnt  = m_c;
        e.tc   = dir ? int'(m_q == MOD - 1) : int'(m_q == 0);
        sb.push_back(e);
    endtask

    task automatic cycle(input logic e, input logic d, input logic c, input logic l, input int lv);
        @(negedge clk);
        en = e; dir = d; clr = c; load = l; load_val = W'(lv);
        @(posedge clk);
        model_step();
        push_exp();
    endtask

    // Asynchronous reset pulse between edges, then an up-count edge.
    task automatic rst_cycle();
        @(negedge clk);
        en = 1'b1; dir = 1'b1; clr = 1'b0; load = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_q", int'(q), 0);
        chk("async_rst_wrap", int'(wrap), 0);
        chk("async_rst_cnt", int'(wrap_cnt), 0);
        #1 rst = 1'b0;
        m_q = 0; m_w = 0; m_c = 0;
        @(posedge clk);
        model_step();
        push_exp();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_item++;
                chk($sformatf("q[%0d]", n_item), int'(q), e.q);
                chk($sformatf("wrap[%0d]", n_item), int'(wrap), e.wrap);
                chk($sformatf("wrap_cnt[%0d]", n_item), int'(wrap_cnt), e.cnt);
                chk($sformatf("tc[%0d]", n_item), int'(tc), e.tc);
                $display("txn %0d: q=%0d wrap=%0d wrap_cnt=%0d tc=%0d", n_item, q, wrap, wrap_cnt, tc);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        #1 rst = 1'b1;
        #2;
        chk("reset_q", int'(q), 0);
        chk("reset_wrap", int'(wrap), 0);
        chk("reset_cnt", int'(wrap_cnt), 0);
        chk("reset_tc_down", int'(tc), 1);
        @(negedge clk);
        rst = 1'b0;

        // Up count through two wraps
        for (int i = 0; i < 25; i++) cycle(1, 1, 0, 0, 0);
        // Clear, then count down across the 0 -> MOD-1 wrap
        cycle(1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
        // clr and load together at the terminal value
        cycle(0, 1, 0, 1, 9);
        cycle(1, 1, 1, 1, 9);
        // Over-range load saturates, then wraps on the next enable
        cycle(0, 1, 0, 1, 15);
        cycle(1, 1, 0, 0, 0);
        // Load coinciding with a wrap condition
        cycle(1, 1, 0, 1, 3);
        cycle(0, 1, 0, 1, 9);
        cycle(1, 1, 0, 1, 2);
        // Wrap counter saturation
        for (int i = 0; i < 45; i++) cycle(1, 1, 0, 0, 0);
        // Direction toggling each cycle
        for (int i = 0; i < 10; i++) cycle(1, logic'(i % 2), 0, 0, 0);
        // Hold after a wrap pulse
        cycle(0, 1, 0, 1, 9);
        cycle(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, logic'(i % 2), 0, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 31) == 0), logic'($urandom_range(0, 15) == 0),
                  int'($urandom_range(0, 15)));
        end
        // Asynchronous reset at q=7 with a nonzero wrap count
        cycle(0, 1, 0, 1, 9);
        cycle(1, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 7);
        rst_cycle();
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
